// File: rtl/bytecode_fetch.sv
`default_nettype none
// ============================================================================
// Module : bytecode_fetch
// Fetches big-endian method code words and streams JVM bytecodes in order.
// Rev    : 1.0  initial release
// ============================================================================
module bytecode_fetch #(
  parameter int ADR_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADR_W-1:0] start_pc,
  input  logic [ADR_W-1:0] code_len,
  input  logic             abort,
  output logic             mem_req,
  output logic [ADR_W-3:0] mem_adr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_data,
  output logic [7:0]       iram_data,
  output logic [ADR_W-1:0] iram_pc,
  output logic             iram_rdy,
  input  logic             iram_next,
  output logic             busy,
  output logic             done
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;

  logic [ADR_W-1:0]   r_fetch_adr;   // byte address of the next byte to fetch
  logic [ADR_W-1:0]   r_remain;      // bytes still to fetch
  logic               r_req;
  logic [ADR_W-1:0]   r_head_pc;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic [7:0]         r_fifo [FIFO_DEPTH];

  logic [1:0]         w_off;
  logic [2:0]         w_avail;
  logic [2:0]         w_n;
  logic               w_ack;
  logic               w_pop;
  logic [c_CNT_W-1:0] w_free;
  logic               w_issue;
  logic [7:0]         w_word_byte [4];
  logic [7:0]         w_enq_byte  [4];

  // Only the first word can start mid-word; every later fetch is aligned.
  assign w_off   = r_fetch_adr[1:0];
  assign w_avail = 3'd4 - {1'b0, w_off};
  assign w_n     = (r_remain < ADR_W'(w_avail)) ? r_remain[2:0] : w_avail;
  assign w_ack   = r_req & mem_ack;
  assign w_pop   = (r_count != '0) & iram_next;
  assign w_free  = c_CNT_W'(FIFO_DEPTH) - r_count + c_CNT_W'(w_pop);
  assign w_issue = (r_state == c_RUN) & ~r_req & (r_remain != '0)
                 & (w_free >= c_CNT_W'(4));

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_word_byte[k] = mem_data[8*(3-k) +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      w_enq_byte[k] = w_word_byte[w_off + 2'(k)];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            w_next_state = (code_len == '0) ? c_DONE : c_RUN;
          end
        end
        c_RUN: begin
          if ((r_remain == '0) && !r_req && (r_count == '0)) begin
            w_next_state = c_DONE;
          end
        end
        c_DONE:  w_next_state = c_IDLE;
        default: w_next_state = c_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state == c_RUN);
    done = (r_state == c_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_adr <= '0;
      r_remain    <= '0;
      r_req       <= 1'b0;
      r_head_pc   <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else if (abort) begin
      // The dropped request clears r_req, so any late ack is ignored.
      r_req   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if ((r_state == c_IDLE) && start) begin
        r_fetch_adr <= start_pc;
        r_remain    <= code_len;
        r_head_pc   <= start_pc;
      end
      if (w_issue) begin
        r_req <= 1'b1;
      end else if (w_ack) begin
        r_req <= 1'b0;
      end
      if (w_ack) begin
        r_fetch_adr <= r_fetch_adr + ADR_W'(w_n);
        r_remain    <= r_remain - ADR_W'(w_n);
        r_wptr      <= r_wptr + c_PTR_W'(w_n);
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + c_PTR_W'(1);
        r_head_pc <= r_head_pc + ADR_W'(1);
      end
      r_count <= r_count + (w_ack ? c_CNT_W'(w_n) : '0) - c_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !abort && w_ack) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < w_n) begin
          r_fifo[r_wptr + c_PTR_W'(k)] <= w_enq_byte[k];
        end
      end
    end
  end

  assign mem_req   = r_req;
  assign mem_adr   = r_fetch_adr[ADR_W-1:2];
  assign iram_rdy  = (r_count != '0);
  assign iram_data = iram_rdy ? r_fifo[r_rptr] : 8'h00;
  assign iram_pc   = r_head_pc;

endmodule
`default_nettype wire

// File: tb/tb_bytecode_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_bytecode_fetch
// Self-checking bench: vector table plus abort/reset/back-pressure sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bytecode_fetch;

  logic        clk = 1'b0;
  logic        reset, start, abort, mem_ack, iram_next;
  logic [15:0] start_pc, code_len, iram_pc;
  logic        mem_req, iram_rdy, busy, done;
  logic [13:0] mem_adr;
  logic [31:0] mem_data;
  logic [7:0]  iram_data;

  bytecode_fetch #(.ADR_W(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .code_len(code_len), .abort(abort), .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_data(mem_data), .iram_data(iram_data),
    .iram_pc(iram_pc), .iram_rdy(iram_rdy), .iram_next(iram_next),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] len;
    int          delay;
    logic [31:0] w0;
    logic [31:0] w1;
    int          reqs;
    logic [7:0]  first;
    logic [7:0]  last;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  data;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [31:0] mem_words [logic [13:0]];

  int          ack_delay = 0, req_cycles = 0, n_reqs = 0, done_cnt = 0, popped = 0;
  int          pop_limit = 1 << 30;
  bit          late_ack = 0, consume_en = 1, busy_seen = 0, prev_ack = 0;
  logic [13:0] held_adr, first_adr;
  logic [7:0]  first_byte, last_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [13:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return {a[7:0], ~a[7:0], a[7:0] ^ 8'h3C, 8'hA5};
  endfunction

  // Memory model: acks after ack_delay cycles, watches request protocol.
  initial begin
    mem_ack = 0; mem_data = 0;
    forever begin
      @(negedge clk);
      if (prev_ack) check("req_low_after_ack", mem_req, 0);
      prev_ack = 0;
      mem_ack  = 0;
      mem_data = 0;
      if (late_ack) begin
        mem_ack  = 1;
        mem_data = 32'hDEADBEEF;
      end else if (mem_req) begin
        if (req_cycles == 0) begin
          if (n_reqs == 0) first_adr = mem_adr;
          n_reqs++;
          held_adr = mem_adr;
        end else begin
          check("mem_adr_hold", mem_adr, held_adr);
        end
        if (req_cycles >= ack_delay) begin
          mem_ack    = 1;
          mem_data   = word_at(mem_adr);
          req_cycles = 0;
          prev_ack   = 1;
        end else begin
          req_cycles++;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // Consumer / scoreboard: compares each byte as it is popped.
  initial begin
    exp_t e;
    iram_next = 0;
    forever begin
      @(negedge clk);
      iram_next = consume_en && (popped < pop_limit);
      if (iram_rdy && iram_next) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %02h at pc %04h, required none", iram_data, iram_pc);
        end else begin
          e = exp_q.pop_front();
          check("iram_data", iram_data, e.data);
          check("iram_pc", iram_pc, e.pc);
        end
        if (popped == 0) first_byte = iram_data;
        last_byte = iram_data;
        popped++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_seen = 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push_expected(input logic [15:0] pc, input logic [15:0] len);
    exp_t        e;
    logic [15:0] a;
    logic [31:0] w;
    for (int i = 0; i < int'(len); i++) begin
      a      = pc + 16'(i);
      w      = word_at(a[15:2]);
      e.pc   = a;
      e.data = 8'(w >> (8 * (3 - int'(a[1:0]))));
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [15:0] pc, input logic [15:0] len);
    start_pc = pc;
    code_len = len;
    start    = 1;
    @(negedge clk);
    start    = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 500 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_case(input vec_t v);
    int lat;
    mem_words[v.pc[15:2]]         = v.w0;
    mem_words[v.pc[15:2] + 14'd1] = v.w1;
    exp_q.delete();
    push_expected(v.pc, v.len);
    ack_delay = v.delay;
    n_reqs = 0; done_cnt = 0; popped = 0;
    do_start(v.pc, v.len);
    lat = 1;
    while (!iram_rdy && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("rdy_latency", lat, 3 + v.delay);
    wait_done();
    check("done_count", done_cnt, 1);
    check("bytes_left", exp_q.size(), 0);
    check("n_reqs", n_reqs, v.reqs);
    check("first_mem_adr", first_adr, v.pc[15:2]);
    check("first_byte", first_byte, v.first);
    check("last_byte", last_byte, v.last);
    check("busy_after", busy, 0);
  endtask

  vec_t vecs [7];

  initial begin
    logic [7:0]  d0;
    logic [15:0] p0;
    bit          ok;

    vecs[0] = '{16'h0010, 16'd5,  0, 32'h1A1B1C1D, 32'h2A2B2C2D, 2, 8'h1A, 8'h2A};
    vecs[1] = '{16'h0013, 16'd2,  0, 32'hAABBCCDD, 32'h11223344, 2, 8'hDD, 8'h11};
    vecs[2] = '{16'h0020, 16'd6,  3, 32'h01020304, 32'h05060708, 2, 8'h01, 8'h06};
    vecs[3] = '{16'hFFFE, 16'd5,  1, 32'hC0C1C2C3, 32'hD0D1D2D3, 2, 8'hC2, 8'hD2};
    vecs[4] = '{16'h0101, 16'd20, 1, 32'hE0E1E2E3, 32'hF0F1F2F3, 6, 8'hE1, 8'h45};
    vecs[5] = '{16'h0500, 16'd6,  0, 32'h51525354, 32'h61626364, 2, 8'h51, 8'h62};
    vecs[6] = '{16'h0602, 16'd3,  2, 32'h71727374, 32'h81828384, 2, 8'h73, 8'h81};

    reset = 0; start = 0; abort = 0; start_pc = 0; code_len = 0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_iram_data", iram_data, 0);
    check("rst_iram_pc", iram_pc, 0);
    check("rst_iram_rdy", iram_rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_case(vecs[i]);

    // Zero length: straight to DONE, no fetch, never busy.
    busy_seen = 0; n_reqs = 0; done_cnt = 0;
    do_start(16'h0030, 16'd0);
    check("zl_done_pulse", done, 1);
    check("zl_busy", busy, 0);
    @(negedge clk);
    check("zl_done_clear", done, 0);
    repeat (3) @(negedge clk);
    check("zl_reqs", n_reqs, 0);
    check("zl_busy_seen", busy_seen, 0);
    check("zl_done_count", done_cnt, 1);

    // Back-pressure: consumer stalls, FIFO fills to exactly two words.
    consume_en = 0; ack_delay = 0; n_reqs = 0; done_cnt = 0; popped = 0;
    exp_q.delete();
    push_expected(16'h0200, 16'd16);
    do_start(16'h0200, 16'd16);
    for (int i = 0; i < 100 && !iram_rdy; i++) @(negedge clk);
    d0 = iram_data;
    p0 = iram_pc;
    check("bp_head_data", d0, 8'h80);
    check("bp_head_pc", p0, 16'h0200);
    ok = 1;
    repeat (20) begin
      @(negedge clk);
      if (iram_data !== d0 || iram_pc !== p0 || !iram_rdy) ok = 0;
    end
    check("bp_stable", ok, 1);
    check("bp_reqs_full", n_reqs, 2);
    check("bp_req_idle", mem_req, 0);
    consume_en = 1;
    wait_done();
    check("bp_done", done_cnt, 1);
    check("bp_drained", exp_q.size(), 0);
    check("bp_reqs_total", n_reqs, 4);

    // Abort after three bytes consumed.
    exp_q.delete();
    n_reqs = 0; done_cnt = 0; popped = 0; pop_limit = 3; ack_delay = 0;
    push_expected(16'h0400, 16'd12);
    do_start(16'h0400, 16'd12);
    for (int i = 0; i < 100 && popped < 3; i++) @(negedge clk);
    check("ab_popped", popped, 3);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("ab_rdy", iram_rdy, 0);
    check("ab_req", mem_req, 0);
    check("ab_busy", busy, 0);
    exp_q.delete();
    late_ack = 1;
    repeat (2) @(negedge clk);
    late_ack = 0;
    repeat (3) @(negedge clk);
    check("ab_late_rdy", iram_rdy, 0);
    check("ab_no_done", done_cnt, 0);
    check("ab_idle_req", mem_req, 0);
    pop_limit = 1 << 30;
    run_case(vecs[5]);

    // Reset in place of abort.
    exp_q.delete();
    n_reqs = 0; done_cnt = 0; popped = 0; pop_limit = 3; ack_delay = 0;
    push_expected(16'h0700, 16'd12);
    do_start(16'h0700, 16'd12);
    for (int i = 0; i < 100 && popped < 3; i++) @(negedge clk);
    check("mr_popped", popped, 3);
    reset = 0;
    @(negedge clk);
    check("mr_mem_req", mem_req, 0);
    check("mr_mem_adr", mem_adr, 0);
    check("mr_iram_data", iram_data, 0);
    check("mr_iram_pc", iram_pc, 0);
    check("mr_iram_rdy", iram_rdy, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    reset = 1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("mr_no_done", done_cnt, 0);
    pop_limit = 1 << 30;
    run_case(vecs[6]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
